rob: RTL and testbench

ROB -- requirements
Module: rob

---
 rtl/rob.sv | 67 ++++++
 tb/tb_rob.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/rob.sv
// rob: in-order reorder buffer with dual allocate (INT older than LS),
// dual completion and up to two in-order retirements per cycle.
module rob #(
  parameter int DEPTH = 16,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             res_n,
  input  logic             valid_int_rat2rob,
  input  logic [5:0]       freeMeUp_int_rat2rob,
  input  logic             valid_ls_rat2rob,
  input  logic [5:0]       freeMeUp_ls_rat2rob,
  input  logic             done_int_ex2rob,
  input  logic [TAG_W-1:0] tag_int_ex2rob,
  input  logic             done_ls_ex2rob,
  input  logic [TAG_W-1:0] tag_ls_ex2rob,
  output logic [TAG_W-1:0] tag_int_rob2rs,
  output logic [TAG_W-1:0] tag_ls_rob2rs,
  output logic             full_rob2id,
  output logic [5:0]       freeMeUp_0_rob2rat,
  output logic [5:0]       freeMeUp_1_rob2rat
);
  logic [TAG_W-1:0] head, tail, head1;
  logic [TAG_W:0]   count;
  logic [DEPTH-1:0] valid, done, done_set, clr, wr_int, wr_ls;
  logic [5:0]       old_reg [DEPTH];
  logic             alloc_int, alloc_ls, ret0, ret1;
  assign full_rob2id    = count > (TAG_W+1)'(DEPTH - 2);
  assign alloc_int      = valid_int_rat2rob & ~full_rob2id;
  assign alloc_ls       = valid_ls_rat2rob & ~full_rob2id;
  assign tag_int_rob2rs = tail;
  assign tag_ls_rob2rs  = tail + TAG_W'(valid_int_rat2rob);
  assign head1          = head + 1'b1;
  // retirement only sees done flags already registered, so completion costs one edge
  assign ret0     = valid[head] & done[head];
  assign ret1     = ret0 & valid[head1] & done[head1];
  assign done_set = ((DEPTH'(done_int_ex2rob) << tag_int_ex2rob) |
                     (DEPTH'(done_ls_ex2rob) << tag_ls_ex2rob)) & valid;
  assign clr      = (DEPTH'(ret0) << head) | (DEPTH'(ret1) << head1);
  assign wr_int   = DEPTH'(alloc_int) << tag_int_rob2rs;
  assign wr_ls    = DEPTH'(alloc_ls) << tag_ls_rob2rs;
  always_ff @(posedge clk) begin
    if (!res_n) begin
      head               <= '0;
      tail               <= '0;
      count              <= '0;
      valid              <= '0;
      done               <= '0;
      freeMeUp_0_rob2rat <= '0;
      freeMeUp_1_rob2rat <= '0;
    end else begin
      head               <= head + TAG_W'(ret0) + TAG_W'(ret1);
      tail               <= tail + TAG_W'(alloc_int) + TAG_W'(alloc_ls);
      count              <= count + (TAG_W+1)'(alloc_int) + (TAG_W+1)'(alloc_ls)
                                  - (TAG_W+1)'(ret0) - (TAG_W+1)'(ret1);
      valid              <= (valid & ~clr) | wr_int | wr_ls;
      done               <= (done | done_set) & ~clr & ~(wr_int | wr_ls);
      freeMeUp_0_rob2rat <= ret0 ? old_reg[head] : '0;
      freeMeUp_1_rob2rat <= ret1 ? old_reg[head1] : '0;
    end
  end
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++)
      if (wr_int[i]) old_reg[i] <= freeMeUp_int_rat2rob;
      else if (wr_ls[i]) old_reg[i] <= freeMeUp_ls_rat2rob;
  end
endmodule

// File: tb/tb_rob.sv
// tb_rob: directed and random stimulus checked against an age-ordered queue model.
module tb_rob;
  localparam int DEPTH = 16;
  localparam int TAG_W = 4;
  logic             clk, res_n;
  logic             valid_int_rat2rob, valid_ls_rat2rob, done_int_ex2rob, done_ls_ex2rob;
  logic [5:0]       freeMeUp_int_rat2rob, freeMeUp_ls_rat2rob;
  logic [TAG_W-1:0] tag_int_ex2rob, tag_ls_ex2rob, tag_int_rob2rs, tag_ls_rob2rs;
  logic             full_rob2id;
  logic [5:0]       freeMeUp_0_rob2rat, freeMeUp_1_rob2rat;
  rob #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .res_n(res_n),
    .valid_int_rat2rob(valid_int_rat2rob), .freeMeUp_int_rat2rob(freeMeUp_int_rat2rob),
    .valid_ls_rat2rob(valid_ls_rat2rob), .freeMeUp_ls_rat2rob(freeMeUp_ls_rat2rob),
    .done_int_ex2rob(done_int_ex2rob), .tag_int_ex2rob(tag_int_ex2rob),
    .done_ls_ex2rob(done_ls_ex2rob), .tag_ls_ex2rob(tag_ls_ex2rob),
    .tag_int_rob2rs(tag_int_rob2rs), .tag_ls_rob2rs(tag_ls_rob2rs),
    .full_rob2id(full_rob2id),
    .freeMeUp_0_rob2rat(freeMeUp_0_rob2rat), .freeMeUp_1_rob2rat(freeMeUp_1_rob2rat)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  typedef struct {int tag; int old; bit done;} ent_t;
  ent_t q[$];
  int next_tag;
  int vectors = 0, miscompares = 0;
  task automatic check(string tag, int got, int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic drive(bit vi, int fi, bit vl, int fl, bit di, int ti, bit dl, int tl);
    valid_int_rat2rob = vi; freeMeUp_int_rat2rob = 6'(fi);
    valid_ls_rat2rob = vl;  freeMeUp_ls_rat2rob = 6'(fl);
    done_int_ex2rob = di;   tag_int_ex2rob = TAG_W'(ti);
    done_ls_ex2rob = dl;    tag_ls_ex2rob = TAG_W'(tl);
  endtask
  task automatic step(bit vi, int fi, bit vl, int fl, bit di, int ti, bit dl, int tl);
    int r0, r1;
    bit full;
    ent_t e;
    drive(vi, fi, vl, fl, di, ti, dl, tl);
    #1;
    full = q.size() > DEPTH - 2;
    check("full", int'(full_rob2id), int'(full));
    if (vi) check("tag_int", int'(tag_int_rob2rs), next_tag);
    if (vl) check("tag_ls", int'(tag_ls_rob2rs), (next_tag + int'(vi)) % DEPTH);
    @(posedge clk);
    r0 = 0; r1 = 0;
    if (q.size() > 0 && q[0].done) begin
      r0 = q[0].old; void'(q.pop_front());
      if (q.size() > 0 && q[0].done) begin r1 = q[0].old; void'(q.pop_front()); end
    end
    foreach (q[i]) if ((di && q[i].tag == ti) || (dl && q[i].tag == tl)) q[i].done = 1;
    if (!full) begin
      if (vi) begin e.tag = next_tag; e.old = fi; e.done = 0; q.push_back(e); next_tag = (next_tag + 1) % DEPTH; end
      if (vl) begin e.tag = next_tag; e.old = fl; e.done = 0; q.push_back(e); next_tag = (next_tag + 1) % DEPTH; end
    end
    #1;
    check("free0", int'(freeMeUp_0_rob2rat), r0);
    check("free1", int'(freeMeUp_1_rob2rat), r1);
    @(negedge clk);
  endtask
  task automatic do_reset(bit noisy);
    if (noisy) drive(1, 5, 1, 6, 1, 0, 1, 1);
    else drive(0, 0, 0, 0, 0, 0, 0, 0);
    res_n = 0;
    @(posedge clk);
    q.delete();
    next_tag = 0;
    #1;
    check("rst_free0", int'(freeMeUp_0_rob2rat), 0);
    check("rst_free1", int'(freeMeUp_1_rob2rat), 0);
    check("rst_full", int'(full_rob2id), 0);
    @(negedge clk);
    res_n = 1;
  endtask
  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  initial begin
    int ti, tl;
    res_n = 0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    do_reset(0);
    // single INT then LS, out-of-order completion
    step(1, 7, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 9, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 1, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0, 0);
    idle();
    idle();
    // dual allocate, dual completion
    do_reset(0);
    step(1, 12, 1, 13, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 1, 1);
    idle();
    idle();
    // fill past the full threshold, then drain one and resume
    do_reset(0);
    for (int i = 0; i < 18; i++) step(1, i + 1, 0, 0, 0, 0, 0, 0);
    step(1, 40, 1, 41, 1, 0, 0, 0);
    step(1, 42, 0, 0, 0, 0, 0, 0);
    step(1, 43, 0, 0, 0, 0, 0, 0);
    // steady-state wrap
    do_reset(0);
    step(1, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i < 20; i++) step(1, i + 1, 0, 0, 1, (i - 1) % DEPTH, 0, 0);
    step(0, 0, 0, 0, 1, 19 % DEPTH, 0, 0);
    idle();
    idle();
    // head blocks retirement of later done entries
    do_reset(0);
    step(1, 20, 1, 21, 0, 0, 0, 0);
    step(1, 0, 1, 23, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 1, 1, 2);
    step(0, 0, 0, 0, 0, 0, 1, 3);
    idle();
    step(0, 0, 0, 0, 1, 0, 0, 0);
    idle();
    idle();
    idle();
    // reset with pending entries and completions in flight
    for (int i = 0; i < 5; i++) step(1, 30 + i, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 1, 1);
    do_reset(1);
    step(1, 50, 0, 0, 0, 0, 0, 0);
    idle();
    // random traffic with occasional resets
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 599) == 0) begin do_reset($urandom_range(0, 1) == 1); continue; end
      ti = (q.size() > 0 && $urandom_range(0, 4) != 0) ? q[$urandom_range(0, q.size() - 1)].tag : $urandom_range(0, DEPTH - 1);
      tl = (q.size() > 0 && $urandom_range(0, 4) != 0) ? q[$urandom_range(0, q.size() - 1)].tag : $urandom_range(0, DEPTH - 1);
      step($urandom_range(0, 1) == 1, ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 63),
           $urandom_range(0, 1) == 1, ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 63),
           $urandom_range(0, 9) < 7, ti, $urandom_range(0, 9) < 7, tl);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
